// File: rtl/reflet_vga_rect_fill.sv
// Rectangle fill engine for the reflet_VGA bitmap write port.
// Takes one command (two corners, colour, alpha), normalises and clips the
// corners to the bitmap, then streams one pixel write per clock in raster
// order. Every output comes straight from a flop. The pixel outputs trail the
// internal state by one cycle, so done lines up with the first IDLE cycle
// and a new command can be taken while done is high.
`timescale 1ns/1ps

module reflet_vga_rect_fill #(
    parameter int color_depth = 2,
    parameter int h_width     = 7,
    parameter int v_width     = 6,
    parameter int h_max       = 80,
    parameter int v_max       = 60
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [h_width-1:0]     x0,
    input  logic [h_width-1:0]     x1,
    input  logic [v_width-1:0]     y0,
    input  logic [v_width-1:0]     y1,
    input  logic [color_depth-1:0] R_in,
    input  logic [color_depth-1:0] G_in,
    input  logic [color_depth-1:0] B_in,
    input  logic [color_depth-1:0] a_in,
    output logic                   write_bitmap,
    output logic [h_width-1:0]     h_pixel,
    output logic [v_width-1:0]     v_pixel,
    output logic [color_depth-1:0] R_out,
    output logic [color_depth-1:0] G_out,
    output logic [color_depth-1:0] B_out,
    output logic [color_depth-1:0] a_out,
    output logic                   busy,
    output logic                   done
);

    // Last valid column / row of the bitmap.
    localparam logic [h_width-1:0] H_LAST = h_width'(h_max - 1);
    localparam logic [v_width-1:0] V_LAST = v_width'(v_max - 1);
    localparam logic [h_width-1:0] H_ONE  = {{(h_width-1){1'b0}}, 1'b1};
    localparam logic [v_width-1:0] V_ONE  = {{(v_width-1){1'b0}}, 1'b1};
    localparam logic [h_width-1:0] H_ZERO = {h_width{1'b0}};
    localparam logic [v_width-1:0] V_ZERO = {v_width{1'b0}};
    localparam logic [color_depth-1:0] C_ZERO = {color_depth{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_DRAW   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched command (raw corners and colour).
    logic [h_width-1:0]     cx0_q, cx1_q;
    logic [v_width-1:0]     cy0_q, cy1_q;
    logic [color_depth-1:0] cr_q, cg_q, cb_q, ca_q;

    // Clipped bounds used while drawing.
    logic [h_width-1:0] xl_q, xr_q;
    logic [v_width-1:0] yb_q;

    // Raster position, aligned with state_q.
    logic [h_width-1:0] h_q, h_d;
    logic [v_width-1:0] v_q, v_d;

    // Output registers.
    logic                   rdy_q;
    logic                   wr_q;
    logic                   busy_q;
    logic                   done_q;
    logic [h_width-1:0]     hpix_q;
    logic [v_width-1:0]     vpix_q;
    logic [color_depth-1:0] rout_q, gout_q, bout_q, aout_q;

    // Normalised / clipped bounds derived from the latched corners.
    logic [h_width-1:0] xl_s, xr_raw_s, xr_s;
    logic [v_width-1:0] yt_s, yb_raw_s, yb_s;
    logic               empty_s;
    logic               accept_s;

    assign accept_s = cmd_valid && rdy_q;

    // Sort the corners, clip the far edges and flag an off-screen rectangle.
    always_comb begin
        xl_s     = (cx0_q < cx1_q) ? cx0_q : cx1_q;
        xr_raw_s = (cx0_q < cx1_q) ? cx1_q : cx0_q;
        yt_s     = (cy0_q < cy1_q) ? cy0_q : cy1_q;
        yb_raw_s = (cy0_q < cy1_q) ? cy1_q : cy0_q;
        if (xr_raw_s > H_LAST) begin
            xr_s = H_LAST;
        end else begin
            xr_s = xr_raw_s;
        end
        if (yb_raw_s > V_LAST) begin
            yb_s = V_LAST;
        end else begin
            yb_s = yb_raw_s;
        end
        empty_s = (xl_s > H_LAST) || (yt_s > V_LAST);
    end

    // Next-state and raster-position logic.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (empty_s) begin
                    // Keep the counters in range; nothing will be drawn.
                    state_d = ST_FINISH;
                end else begin
                    h_d     = xl_s;
                    v_d     = yt_s;
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (h_q == xr_q) begin
                    if (v_q == yb_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        h_d = xl_q;
                        v_d = v_q + V_ONE;
                    end
                end else begin
                    h_d = h_q + H_ONE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and raster-position registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            h_q     <= H_ZERO;
            v_q     <= V_ZERO;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    // Capture the command on accept so later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx0_q <= H_ZERO;
            cx1_q <= H_ZERO;
            cy0_q <= V_ZERO;
            cy1_q <= V_ZERO;
            cr_q  <= C_ZERO;
            cg_q  <= C_ZERO;
            cb_q  <= C_ZERO;
            ca_q  <= C_ZERO;
        end else if (accept_s) begin
            cx0_q <= x0;
            cx1_q <= x1;
            cy0_q <= y0;
            cy1_q <= y1;
            cr_q  <= R_in;
            cg_q  <= G_in;
            cb_q  <= B_in;
            ca_q  <= a_in;
        end else begin
            cx0_q <= cx0_q;
            cx1_q <= cx1_q;
            cy0_q <= cy0_q;
            cy1_q <= cy1_q;
            cr_q  <= cr_q;
            cg_q  <= cg_q;
            cb_q  <= cb_q;
            ca_q  <= ca_q;
        end
    end

    // Freeze the clipped bounds during SETUP for use by the DRAW walk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xl_q <= H_ZERO;
            xr_q <= H_ZERO;
            yb_q <= V_ZERO;
        end else if (state_q == ST_SETUP) begin
            xl_q <= xl_s;
            xr_q <= xr_s;
            yb_q <= yb_s;
        end else begin
            xl_q <= xl_q;
            xr_q <= xr_q;
            yb_q <= yb_q;
        end
    end

    // Output stage: strobes and pixel data trail state_q by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q  <= 1'b1;
            wr_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hpix_q <= H_ZERO;
            vpix_q <= V_ZERO;
        end else begin
            rdy_q  <= (state_d == ST_IDLE);
            wr_q   <= (state_q == ST_DRAW);
            busy_q <= (state_q == ST_SETUP) || (state_q == ST_DRAW);
            done_q <= (state_q == ST_FINISH);
            hpix_q <= h_q;
            vpix_q <= v_q;
        end
    end

    // Colour outputs are loaded once per command, during SETUP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rout_q <= C_ZERO;
            gout_q <= C_ZERO;
            bout_q <= C_ZERO;
            aout_q <= C_ZERO;
        end else if (state_q == ST_SETUP) begin
            rout_q <= cr_q;
            gout_q <= cg_q;
            bout_q <= cb_q;
            aout_q <= ca_q;
        end else begin
            rout_q <= rout_q;
            gout_q <= gout_q;
            bout_q <= bout_q;
            aout_q <= aout_q;
        end
    end

    assign cmd_ready    = rdy_q;
    assign write_bitmap = wr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign h_pixel      = hpix_q;
    assign v_pixel      = vpix_q;
    assign R_out        = rout_q;
    assign G_out        = gout_q;
    assign B_out        = bout_q;
    assign a_out        = aout_q;

endmodule

// File: tb/tb_reflet_vga_rect_fill.sv
// Scoreboard bench for reflet_vga_rect_fill: stimulus pushes hand-computed
// pixels and done events; a monitor pops and compares on every write/done.
`timescale 1ns/1ps

module tb_reflet_vga_rect_fill;

    localparam int CD = 2;
    localparam int HW = 7;
    localparam int VW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [HW-1:0] x0, x1;
    logic [VW-1:0] y0, y1;
    logic [CD-1:0] R_in, G_in, B_in, a_in;
    logic          write_bitmap;
    logic [HW-1:0] h_pixel;
    logic [VW-1:0] v_pixel;
    logic [CD-1:0] R_out, G_out, B_out, a_out;
    logic          busy;
    logic          done;

    reflet_vga_rect_fill dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .R_in(R_in), .G_in(G_in), .B_in(B_in), .a_in(a_in),
        .write_bitmap(write_bitmap), .h_pixel(h_pixel), .v_pixel(v_pixel),
        .R_out(R_out), .G_out(G_out), .B_out(B_out), .a_out(a_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        int rgba;
        bit first;
    } px_t;

    px_t exp_px[$];
    bit  exp_done[$];   // 1 = empty rectangle (done two cycles after accept)

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_wr_cyc = 0;
    int last_done_cyc = 0;
    int wr_total = 0;
    int done_total = 0;
    int busy_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pack_rgba(input int r, input int g, input int b, input int a);
        return (r << 6) | (g << 4) | (b << 2) | a;
    endfunction

    task automatic push_px(input int h, input int v, input int rgba, input bit first);
        px_t e;
        e.h = h; e.v = v; e.rgba = rgba; e.first = first;
        exp_px.push_back(e);
    endtask

    // Issue a command; returns #1 after the accepting edge.
    task automatic send(input int ax0, input int ax1, input int ay0, input int ay1,
                        input int r, input int g, input int b, input int a, input bit hold);
        int n;
        x0 = HW'(ax0); x1 = HW'(ax1); y0 = VW'(ay0); y1 = VW'(ay1);
        R_in = CD'(r); G_in = CD'(g); B_in = CD'(b); a_in = CD'(a);
        cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_px.size() != 0 || exp_done.size() != 0 || busy) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_pending", exp_px.size() + exp_done.size(), 0);
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Monitor: compare every write and done against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            if (busy) busy_cnt++;
            if (write_bitmap) begin
                px_t e;
                wr_total++;
                chk("write_expected", int'(exp_px.size() != 0), 1);
                if (exp_px.size() != 0) begin
                    e = exp_px.pop_front();
                    chk("pixel_h", int'(h_pixel), e.h);
                    chk("pixel_v", int'(v_pixel), e.v);
                    chk("pixel_rgba", int'({R_out, G_out, B_out, a_out}), e.rgba);
                    if (e.first) chk("first_write_latency", cyc, acc_cyc + 2);
                    else         chk("writes_contiguous", cyc, last_wr_cyc + 1);
                end
                last_wr_cyc = cyc;
            end
            if (done) begin
                bit emp;
                done_total++;
                chk("done_expected", int'(exp_done.size() != 0), 1);
                if (exp_done.size() != 0) begin
                    emp = exp_done.pop_front();
                    chk("done_timing", cyc, emp ? acc_cyc + 2 : last_wr_cyc + 1);
                    chk("done_busy_low", int'(busy), 0);
                    chk("done_ready_high", int'(cmd_ready), 1);
                end
                last_done_cyc = cyc;
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_wr, base_done, n;
        reset = 1'b1; cmd_valid = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0;
        R_in = '0; G_in = '0; B_in = '0; a_in = '0;
        #1 reset = 1'b0;
        #11;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_write", int'(write_bitmap), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_hv", int'({h_pixel, v_pixel}), 0);
        chk("rst_rgba", int'({R_out, G_out, B_out, a_out}), 0);
        @(negedge clk) reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_no_writes", wr_total, 0);

        // 3x2 rectangle, red with alpha 2.
        push_px(10, 10, pack_rgba(3, 0, 0, 2), 1'b1);
        push_px(11, 10, pack_rgba(3, 0, 0, 2), 1'b0);
        push_px(12, 10, pack_rgba(3, 0, 0, 2), 1'b0);
        push_px(10, 11, pack_rgba(3, 0, 0, 2), 1'b0);
        push_px(11, 11, pack_rgba(3, 0, 0, 2), 1'b0);
        push_px(12, 11, pack_rgba(3, 0, 0, 2), 1'b0);
        exp_done.push_back(1'b0);
        busy_cnt = 0;
        send(10, 12, 10, 11, 3, 0, 0, 2, 1'b0);
        wait_idle();
        chk("busy_cycles_3x2", busy_cnt, 7);

        // Swapped corners.
        push_px(3, 2, pack_rgba(1, 2, 3, 1), 1'b1);
        push_px(4, 2, pack_rgba(1, 2, 3, 1), 1'b0);
        push_px(5, 2, pack_rgba(1, 2, 3, 1), 1'b0);
        exp_done.push_back(1'b0);
        send(5, 3, 2, 2, 1, 2, 3, 1, 1'b0);
        wait_idle();

        // Clipped to the bottom-right corner.
        push_px(78, 59, pack_rgba(2, 1, 0, 3), 1'b1);
        push_px(79, 59, pack_rgba(2, 1, 0, 3), 1'b0);
        exp_done.push_back(1'b0);
        send(78, 100, 59, 63, 2, 1, 0, 3, 1'b0);
        wait_idle();

        // Fully off-screen: no writes, busy one cycle, done.
        base_wr = wr_total;
        exp_done.push_back(1'b1);
        busy_cnt = 0;
        send(90, 90, 5, 5, 1, 1, 1, 1, 1'b0);
        wait_idle();
        chk("empty_busy_cycles", busy_cnt, 1);
        chk("empty_no_writes", wr_total - base_wr, 0);

        // Single pixel; inputs change right after accept.
        push_px(1, 1, pack_rgba(0, 0, 3, 0), 1'b1);
        exp_done.push_back(1'b0);
        send(1, 1, 1, 1, 0, 0, 3, 0, 1'b0);
        R_in = 2'd3; G_in = 2'd3; B_in = 2'd0; a_in = 2'd3; x0 = 7'd50; y1 = 6'd40;
        wait_idle();

        // Reset mid-fill of a 20x20 rectangle.
        base_done = done_total;
        base_wr = wr_total;
        for (int v = 0; v < 20; v++)
            for (int h = 0; h < 20; h++)
                push_px(h, v, pack_rgba(1, 1, 1, 1), (h == 0 && v == 0));
        exp_done.push_back(1'b0);
        send(0, 19, 0, 19, 1, 1, 1, 1, 1'b0);
        n = 0;
        while (wr_total - base_wr < 30 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("midfill_writes_seen", int'(wr_total - base_wr >= 30), 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_write", int'(write_bitmap), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_ready", int'(cmd_ready), 1);
        exp_px.delete();
        exp_done.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_total - base_done, 0);
        push_px(7, 3, pack_rgba(3, 2, 1, 0), 1'b1);
        exp_done.push_back(1'b0);
        send(7, 7, 3, 3, 3, 2, 1, 0, 1'b0);
        wait_idle();
        chk("fresh_cmd_done", done_total - base_done, 1);

        // Back-to-back with cmd_valid held high.
        push_px(2, 4, pack_rgba(1, 0, 1, 0), 1'b1);
        push_px(3, 4, pack_rgba(1, 0, 1, 0), 1'b0);
        exp_done.push_back(1'b0);
        send(2, 3, 4, 4, 1, 0, 1, 0, 1'b1);
        push_px(0, 0, pack_rgba(0, 1, 0, 1), 1'b1);
        push_px(0, 1, pack_rgba(0, 1, 0, 1), 1'b0);
        exp_done.push_back(1'b0);
        send(0, 0, 0, 1, 0, 1, 0, 1, 1'b0);
        chk("b2b_accept_on_done", acc_cyc, last_done_cyc + 1);
        wait_idle();

        chk("final_scoreboard_empty", exp_px.size() + exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
